// File: rtl/video_timing_pkg.sv
// Shared mode constants and width helpers for the raster timing generator.
package video_timing_pkg;

    localparam int unsigned VGA_640X480_60_H_ACTIVE = 640;
    localparam int unsigned VGA_640X480_60_H_FRONT  = 16;
    localparam int unsigned VGA_640X480_60_H_SYNC   = 96;
    localparam int unsigned VGA_640X480_60_H_BACK   = 48;
    localparam int unsigned VGA_640X480_60_V_ACTIVE = 480;
    localparam int unsigned VGA_640X480_60_V_FRONT  = 10;
    localparam int unsigned VGA_640X480_60_V_SYNC   = 2;
    localparam int unsigned VGA_640X480_60_V_BACK   = 33;

    // Bits needed to count 0..n-1 (minimum 1).
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 1;
        for (int unsigned i = 1; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) r = i + 1;
        end
        return r;
    endfunction

    function automatic int unsigned axis_total(input int unsigned active, input int unsigned front,
                                               input int unsigned sync, input int unsigned back);
        return active + front + sync + back;
    endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// Pixel-domain raster bus; fetch lookahead signals exist only with VTG_FETCH_EN.
interface video_timing_gen_if #(
    parameter int unsigned X_W = 10,
    parameter int unsigned Y_W = 9
);
    logic           pix_ce;
    logic           restart;
    logic           HS;
    logic           VS;
    logic           blank_n;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic           line_start;
    logic           frame_start;
    logic           vblank_start;
`ifdef VTG_FETCH_EN
    logic [X_W-1:0] fetch_x;
    logic [Y_W-1:0] fetch_y;
    logic           fetch_valid;

    modport master (input pix_ce, restart,
                    output HS, VS, blank_n, x, y, line_start, frame_start, vblank_start,
                    fetch_x, fetch_y, fetch_valid);
    modport slave  (output pix_ce, restart,
                    input HS, VS, blank_n, x, y, line_start, frame_start, vblank_start,
                    fetch_x, fetch_y, fetch_valid);
`else
    modport master (input pix_ce, restart,
                    output HS, VS, blank_n, x, y, line_start, frame_start, vblank_start);
    modport slave  (output pix_ce, restart,
                    input HS, VS, blank_n, x, y, line_start, frame_start, vblank_start);
`endif
endinterface

// File: rtl/vtg_axis_counter.sv
// Wrapping position counter: restart loads LOAD, ce advances 0..LAST and wraps.
module vtg_axis_counter #(
    parameter int unsigned W    = 4,
    parameter int unsigned LAST = 1,
    parameter int unsigned LOAD = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ce_i,
    input  logic         restart_i,
    output logic [W-1:0] cnt_o
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (restart_i) begin
            cnt_d = W'(LOAD);
        end else if (ce_i) begin
            cnt_d = (cnt_q == W'(LAST)) ? '0 : cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= W'(LOAD);
        else        cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator with registered, mutually aligned outputs.
// Define VTG_FETCH_EN to build the LEAD-pixel lookahead fetch coordinates.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = VGA_640X480_60_H_ACTIVE,
    parameter int unsigned H_FRONT  = VGA_640X480_60_H_FRONT,
    parameter int unsigned H_SYNC   = VGA_640X480_60_H_SYNC,
    parameter int unsigned H_BACK   = VGA_640X480_60_H_BACK,
    parameter int unsigned V_ACTIVE = VGA_640X480_60_V_ACTIVE,
    parameter int unsigned V_FRONT  = VGA_640X480_60_V_FRONT,
    parameter int unsigned V_SYNC   = VGA_640X480_60_V_SYNC,
    parameter int unsigned V_BACK   = VGA_640X480_60_V_BACK,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0,
    parameter int unsigned X_W      = 10,
    parameter int unsigned Y_W      = 9,
    parameter int unsigned LEAD     = 2
) (
    input  logic               vga_clk,
    input  logic               reset_n,
    video_timing_gen_if.master vif
);
    localparam int unsigned H_TOTAL = axis_total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK);
    localparam int unsigned V_TOTAL = axis_total(V_ACTIVE, V_FRONT, V_SYNC, V_BACK);
    localparam int unsigned H_W     = clog2(H_TOTAL);
    localparam int unsigned V_W     = clog2(V_TOTAL);
    localparam int unsigned HS_BEG  = H_ACTIVE + H_FRONT;
    localparam int unsigned HS_END  = HS_BEG + H_SYNC;
    localparam int unsigned VS_BEG  = V_ACTIVE + V_FRONT;
    localparam int unsigned VS_END  = VS_BEG + V_SYNC;

    if (LEAD < 1 || LEAD >= H_TOTAL - H_ACTIVE ||
        X_W < clog2(H_ACTIVE) || Y_W < clog2(V_ACTIVE)) begin : g_bad_cfg
        $error("video_timing_gen: LEAD or x/y width out of range");
    end

    logic [H_W-1:0] h;
    logic [V_W-1:0] v;
    logic           h_wrap_c;

    assign h_wrap_c = vif.pix_ce && (h == H_W'(H_TOTAL - 1));

    vtg_axis_counter #(.W(H_W), .LAST(H_TOTAL - 1), .LOAD(0)) u_h_cnt (
        .clk(vga_clk), .rst_n(reset_n), .ce_i(vif.pix_ce), .restart_i(vif.restart), .cnt_o(h)
    );
    vtg_axis_counter #(.W(V_W), .LAST(V_TOTAL - 1), .LOAD(0)) u_v_cnt (
        .clk(vga_clk), .rst_n(reset_n), .ce_i(h_wrap_c), .restart_i(vif.restart), .cnt_o(v)
    );

    // Decode of the current position; registered below on the same ce edge.
    logic vis_c, hs_act_c, vs_act_c, h_zero_c;
    assign vis_c    = (32'(h) < H_ACTIVE) && (32'(v) < V_ACTIVE);
    assign hs_act_c = (32'(h) >= HS_BEG) && (32'(h) < HS_END);
    assign vs_act_c = (32'(v) >= VS_BEG) && (32'(v) < VS_END);
    assign h_zero_c = (h == '0);

    logic           hs_q, hs_d, vs_q, vs_d, blank_n_q, blank_n_d;
    logic [X_W-1:0] x_q, x_d;
    logic [Y_W-1:0] y_q, y_d;
    logic           line_start_q, line_start_d, frame_start_q, frame_start_d;
    logic           vblank_start_q, vblank_start_d;

    always_comb begin
        hs_d           = hs_q;
        vs_d           = vs_q;
        blank_n_d      = blank_n_q;
        x_d            = x_q;
        y_d            = y_q;
        line_start_d   = line_start_q;
        frame_start_d  = frame_start_q;
        vblank_start_d = vblank_start_q;
        if (vif.restart) begin
            hs_d           = ~HS_POL;
            vs_d           = ~VS_POL;
            blank_n_d      = 1'b0;
            x_d            = '0;
            y_d            = '0;
            line_start_d   = 1'b0;
            frame_start_d  = 1'b0;
            vblank_start_d = 1'b0;
        end else if (vif.pix_ce) begin
            hs_d           = hs_act_c ? HS_POL : ~HS_POL;
            vs_d           = vs_act_c ? VS_POL : ~VS_POL;
            blank_n_d      = vis_c;
            x_d            = vis_c ? X_W'(h) : '0;
            y_d            = vis_c ? Y_W'(v) : '0;
            line_start_d   = h_zero_c;
            frame_start_d  = h_zero_c && (v == '0);
            vblank_start_d = h_zero_c && (32'(v) == V_ACTIVE);
        end
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            hs_q           <= ~HS_POL;
            vs_q           <= ~VS_POL;
            blank_n_q      <= 1'b0;
            x_q            <= '0;
            y_q            <= '0;
            line_start_q   <= 1'b0;
            frame_start_q  <= 1'b0;
            vblank_start_q <= 1'b0;
        end else begin
            hs_q           <= hs_d;
            vs_q           <= vs_d;
            blank_n_q      <= blank_n_d;
            x_q            <= x_d;
            y_q            <= y_d;
            line_start_q   <= line_start_d;
            frame_start_q  <= frame_start_d;
            vblank_start_q <= vblank_start_d;
        end
    end

    assign vif.HS           = hs_q;
    assign vif.VS           = vs_q;
    assign vif.blank_n      = blank_n_q;
    assign vif.x            = x_q;
    assign vif.y            = y_q;
    assign vif.line_start   = line_start_q;
    assign vif.frame_start  = frame_start_q;
    assign vif.vblank_start = vblank_start_q;

`ifdef VTG_FETCH_EN
    // Second raster pair running LEAD pixels ahead of the display pair.
    logic [H_W-1:0] fh;
    logic [V_W-1:0] fv;
    logic           fh_wrap_c, fvis_c;

    assign fh_wrap_c = vif.pix_ce && (fh == H_W'(H_TOTAL - 1));
    assign fvis_c    = (32'(fh) < H_ACTIVE) && (32'(fv) < V_ACTIVE);

    vtg_axis_counter #(.W(H_W), .LAST(H_TOTAL - 1), .LOAD(LEAD)) u_fh_cnt (
        .clk(vga_clk), .rst_n(reset_n), .ce_i(vif.pix_ce), .restart_i(vif.restart), .cnt_o(fh)
    );
    vtg_axis_counter #(.W(V_W), .LAST(V_TOTAL - 1), .LOAD(0)) u_fv_cnt (
        .clk(vga_clk), .rst_n(reset_n), .ce_i(fh_wrap_c), .restart_i(vif.restart), .cnt_o(fv)
    );

    logic           fetch_valid_q, fetch_valid_d;
    logic [X_W-1:0] fetch_x_q, fetch_x_d;
    logic [Y_W-1:0] fetch_y_q, fetch_y_d;

    always_comb begin
        fetch_valid_d = fetch_valid_q;
        fetch_x_d     = fetch_x_q;
        fetch_y_d     = fetch_y_q;
        if (vif.restart) begin
            fetch_valid_d = 1'b0;
            fetch_x_d     = '0;
            fetch_y_d     = '0;
        end else if (vif.pix_ce) begin
            fetch_valid_d = fvis_c;
            fetch_x_d     = fvis_c ? X_W'(fh) : '0;
            fetch_y_d     = fvis_c ? Y_W'(fv) : '0;
        end
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_valid_q <= 1'b0;
            fetch_x_q     <= '0;
            fetch_y_q     <= '0;
        end else begin
            fetch_valid_q <= fetch_valid_d;
            fetch_x_q     <= fetch_x_d;
            fetch_y_q     <= fetch_y_d;
        end
    end

    assign vif.fetch_valid = fetch_valid_q;
    assign vif.fetch_x     = fetch_x_q;
    assign vif.fetch_y     = fetch_y_q;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen in a 15x8 raster; reference model works on a linear frame position.
module tb_video_timing_gen;
    localparam int HA = 8, HF = 2, HSY = 3, HB = 2, HT = HA + HF + HSY + HB;
    localparam int VA = 4, VF = 1, VSY = 2, VB = 1, VT = VA + VF + VSY + VB;
    localparam int FRAME = HT * VT;
    localparam int LEAD = 2;
    localparam int XW = 3, YW = 2;
`ifdef VTG_FETCH_EN
    localparam int OBS_W = 19;
`else
    localparam int OBS_W = 13;
`endif

    logic vga_clk = 1'b0;
    logic reset_n;
    always #5 vga_clk = ~vga_clk;

    video_timing_gen_if #(.X_W(XW), .Y_W(YW)) vif0 ();
    video_timing_gen_if #(.X_W(XW), .Y_W(YW)) vif1 ();

    video_timing_gen #(
        .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HSY), .H_BACK(HB),
        .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VSY), .V_BACK(VB),
        .HS_POL(1'b0), .VS_POL(1'b0), .X_W(XW), .Y_W(YW), .LEAD(LEAD)
    ) u_dut0 (.vga_clk(vga_clk), .reset_n(reset_n), .vif(vif0));

    video_timing_gen #(
        .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HSY), .H_BACK(HB),
        .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VSY), .V_BACK(VB),
        .HS_POL(1'b1), .VS_POL(1'b1), .X_W(XW), .Y_W(YW), .LEAD(LEAD)
    ) u_dut1 (.vga_clk(vga_clk), .reset_n(reset_n), .vif(vif1));

    typedef struct {
        bit hs_act, vs_act, vis, ls, fs, vbs, fv;
        int x, y, fx, fy;
    } exp_t;

    exp_t e;
    int   pos;
    int   checks = 0;
    int   errors = 0;

    // Expected outputs when the raster presents linear position p.
    function automatic exp_t decode(input int p);
        exp_t r;
        int h, v, fp, fh, fvv;
        h = p % HT;
        v = p / HT;
        r.vis    = (h < HA) && (v < VA);
        r.x      = r.vis ? h : 0;
        r.y      = r.vis ? v : 0;
        r.hs_act = (h >= HA + HF) && (h < HA + HF + HSY);
        r.vs_act = (v >= VA + VF) && (v < VA + VF + VSY);
        r.ls     = (h == 0);
        r.fs     = (p == 0);
        r.vbs    = (h == 0) && (v == VA);
        fp  = (p + LEAD) % FRAME;
        fh  = fp % HT;
        fvv = fp / HT;
        r.fv = (fh < HA) && (fvv < VA);
        r.fx = r.fv ? fh : 0;
        r.fy = r.fv ? fvv : 0;
        return r;
    endfunction

    function automatic exp_t inactive();
        exp_t r;
        r = '{default: 0};
        return r;
    endfunction

    function automatic logic [OBS_W-1:0] obs_vec();
        return {vif0.HS, vif0.VS, vif0.blank_n, vif0.x, vif0.y, vif0.line_start,
                vif0.frame_start, vif0.vblank_start, vif1.HS, vif1.VS
`ifdef VTG_FETCH_EN
                , vif0.fetch_valid, vif0.fetch_x, vif0.fetch_y
`endif
               };
    endfunction

    function automatic logic [OBS_W-1:0] exp_vec();
        return {~e.hs_act, ~e.vs_act, e.vis, XW'(e.x), YW'(e.y), e.ls, e.fs, e.vbs,
                e.hs_act, e.vs_act
`ifdef VTG_FETCH_EN
                , e.fv, XW'(e.fx), YW'(e.fy)
`endif
               };
    endfunction

    // One clock: drive inputs, advance the model on the edge, sample 1 time unit later.
    task automatic step(input logic ce, input logic rs);
        vif0.pix_ce = ce; vif1.pix_ce = ce;
        vif0.restart = rs; vif1.restart = rs;
        @(posedge vga_clk);
        if (rs) begin
            e = inactive();
            pos = 0;
        end else if (ce) begin
            e = decode(pos);
            pos = (pos + 1) % FRAME;
        end
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        vif0.pix_ce = 1'b0; vif1.pix_ce = 1'b0;
        vif0.restart = 1'b0; vif1.restart = 1'b0;
        e = inactive();
        pos = 0;
        repeat (3) @(posedge vga_clk);
        #1;
        checks++;
        if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL reset_values: got %h exp %h", obs_vec(), exp_vec());
        end
        reset_n = 1'b1;
    endtask

    task automatic test_full_frame();
        logic [7:0] lm, lm_exp;
        bit         spot;
        for (int i = 0; i <= FRAME; i++) begin
            step(1'b1, 1'b0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL frame edge %0d: got %h exp %h", i, obs_vec(), exp_vec());
            end
            lm = {vif0.HS, vif0.VS, vif0.blank_n, vif0.line_start, vif0.frame_start,
                  vif0.vblank_start, vif0.y};
            spot = 1'b1;
            lm_exp = 8'h00;
            case (i)
                0:       lm_exp = 8'b1111_1000;
                8:       lm_exp = 8'b1100_0000;
                10, 12:  lm_exp = 8'b0100_0000;
                13:      lm_exp = 8'b1100_0000;
                15:      lm_exp = 8'b1111_0001;
                60:      lm_exp = 8'b1101_0100;
                75:      lm_exp = 8'b1001_0000;
                104:     lm_exp = 8'b1000_0000;
                105:     lm_exp = 8'b1101_0000;
                120:     lm_exp = 8'b1111_1000;
                default: spot = 1'b0;
            endcase
            if (spot) begin
                checks++;
                if (lm !== lm_exp) begin
                    errors++;
                    $display("FAIL landmark edge %0d: got %b exp %b", i, lm, lm_exp);
                end
            end
        end
    endtask

    task automatic test_ce_divided();
        int run;
        run = 0;
        for (int c = 0; c < 3 * FRAME + 6; c++) begin
            step((c % 3) == 0, 1'b0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL ce_div cycle %0d: got %h exp %h", c, obs_vec(), exp_vec());
            end
            if (vif0.line_start === 1'b1) begin
                run++;
            end else if (run != 0) begin
                checks++;
                if (run != 3) begin
                    errors++;
                    $display("FAIL pulse_width cycle %0d: got %0d exp 3", c, run);
                end
                run = 0;
            end
        end
    endtask

    task automatic test_restart();
        logic [7:0] got;
        for (int k = 0; k < FRAME + 2 && pos != 2 * HT + 6; k++) step(1'b1, 1'b0);
        checks++;
        if (pos != 2 * HT + 6) begin
            errors++;
            $display("FAIL restart_seek: got pos %0d exp %0d", pos, 2 * HT + 6);
        end
        step(1'b0, 1'b1);
        checks++;
        if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL restart_noce: got %h exp %h", obs_vec(), exp_vec());
        end
        checks++;
        if ({vif0.HS, vif0.blank_n, vif0.frame_start, vif0.line_start} !== 4'b1000) begin
            errors++;
            $display("FAIL restart_inactive: got %b exp 1000",
                     {vif0.HS, vif0.blank_n, vif0.frame_start, vif0.line_start});
        end
        repeat (2) begin
            step(1'b0, 1'b0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL restart_hold: got %h exp %h", obs_vec(), exp_vec());
            end
        end
        step(1'b1, 1'b0);
        got = {vif0.frame_start, vif0.line_start, vif0.blank_n, vif0.x, vif0.y};
        checks++;
        if (got !== 8'b1110_0000) begin
            errors++;
            $display("FAIL restart_first_ce: got %b exp 11100000", got);
        end
        repeat (7) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        checks++;
        if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL restart_with_ce: got %h exp %h", obs_vec(), exp_vec());
        end
        step(1'b1, 1'b0);
        checks++;
        if (obs_vec() !== exp_vec() || vif0.frame_start !== 1'b1) begin
            errors++;
            $display("FAIL restart_with_ce_next: got %h exp %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_reset_midframe();
        repeat (23) step(1'b1, 1'b0);
        #2;
        reset_n = 1'b0;
        e = inactive();
        pos = 0;
        #1;
        checks++;
        if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL async_reset: got %h exp %h", obs_vec(), exp_vec());
        end
        @(posedge vga_clk);
        #1;
        reset_n = 1'b1;
        step(1'b1, 1'b0);
        checks++;
        if (obs_vec() !== exp_vec() || vif0.frame_start !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_first: got %h exp %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_random();
        logic ce, rs;
        for (int c = 0; c < 3000; c++) begin
            ce = 1'($urandom_range(0, 1));
            rs = ($urandom_range(0, 63) == 0);
            step(ce, rs);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random cycle %0d ce=%0b rs=%0b: got %h exp %h",
                         c, ce, rs, obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_ce_divided();
        test_restart();
        test_reset_midframe();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
